// File: rtl/bus_memory.sv
// rtl/bus_memory.sv - main-memory responder for the CPU external bus (optional BUSMEM_PARITY_EN)
module bus_memory #(
  parameter int AW      = 20,
  parameter int DW_LOG2 = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] bus_ad,
  input  logic [7:0]  bus_tag,
  input  logic        bus_astb,
  input  logic        bus_atomic,
  input  logic        bus_rd,
  input  logic        bus_wr,
  output logic [63:0] rd_data,
  output logic [7:0]  rd_tag,
  output logic        err,
  output logic [31:0] nreads,
  output logic [31:0] nwrites
);

`ifdef BUSMEM_PARITY_EN
  localparam int MW = 73;
`else
  localparam int MW = 72;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, LOCK = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q;
  logic [MW-1:0]       mem [0:(1<<DW_LOG2)-1];
  logic [MW-1:0]       rd_word;
  logic [MW-1:0]       wr_word;
  logic [DW_LOG2-1:0]  idx;
  logic                in_range;
  logic                latch_addr, do_read, do_write, proto_err;

  assign idx      = addr_q[DW_LOG2-1:0];
  assign in_range = (addr_q[AW-1:DW_LOG2] == '0);
  assign rd_word  = mem[idx];

`ifdef BUSMEM_PARITY_EN
  assign wr_word = {^{bus_tag, bus_ad}, bus_tag, bus_ad};
`else
  assign wr_word = {bus_tag, bus_ad};
`endif

  // Illegal combinations are rejected before the per-state decode so they never change state.
  always_comb begin
    state_d    = state_q;
    latch_addr = 1'b0;
    do_read    = 1'b0;
    do_write   = 1'b0;
    proto_err  = 1'b0;
    if ((bus_rd && bus_wr) || (bus_astb && (bus_rd || bus_wr))) begin
      proto_err = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_rd || bus_wr) begin
            proto_err = 1'b1;
          end else if (bus_astb) begin
            latch_addr = 1'b1;
            state_d    = ADDR;
          end
        end
        ADDR: begin
          if (bus_astb) begin
            latch_addr = 1'b1;
          end else if (bus_rd) begin
            do_read = 1'b1;
            if (bus_atomic) state_d = LOCK;
          end else if (bus_wr) begin
            do_write = 1'b1;
          end
        end
        LOCK: begin
          if (bus_astb || bus_rd) begin
            proto_err = 1'b1;
          end else if (bus_wr) begin
            do_write = 1'b1;
            state_d  = ADDR;
          end else if (!bus_atomic) begin
            proto_err = 1'b1;
            state_d   = ADDR;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_data <= '0;
      rd_tag  <= '0;
      err     <= 1'b0;
      nreads  <= '0;
      nwrites <= '0;
    end else begin
      state_q <= state_d;
      if (latch_addr) addr_q <= bus_ad[AW-1:0];
      if (proto_err) err <= 1'b1;
      if (do_read) begin
        nreads <= nreads + 32'd1;
        if (in_range) begin
          rd_data <= rd_word[63:0];
          rd_tag  <= rd_word[71:64];
`ifdef BUSMEM_PARITY_EN
          if (^rd_word) err <= 1'b1;
`endif
        end else begin
          rd_data <= '0;
          rd_tag  <= '0;
          err     <= 1'b1;
        end
      end
      if (do_write) begin
        if (in_range) nwrites <= nwrites + 32'd1;
        else          err     <= 1'b1;
      end
    end
  end

  // Storage has no reset; a write is suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset && do_write && in_range) mem[idx] <= wr_word;
  end

endmodule

// File: tb/tb_bus_memory.sv
// tb/tb_bus_memory.sv - directed self-checking bench for bus_memory
module tb_bus_memory;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] bus_ad;
  logic [7:0]  bus_tag;
  logic        bus_astb, bus_atomic, bus_rd, bus_wr;
  logic [63:0] rd_data;
  logic [7:0]  rd_tag;
  logic        err;
  logic [31:0] nreads, nwrites;
  int          checks = 0;
  int          failures = 0;

  bus_memory dut (
    .clk(clk), .reset(reset), .bus_ad(bus_ad), .bus_tag(bus_tag),
    .bus_astb(bus_astb), .bus_atomic(bus_atomic), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .rd_data(rd_data), .rd_tag(rd_tag), .err(err), .nreads(nreads), .nwrites(nwrites)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst_n, input logic astb, input logic atomic,
                     input logic rd, input logic wr, input logic [63:0] ad, input logic [7:0] tg);
    reset = rst_n; bus_astb = astb; bus_atomic = atomic; bus_rd = rd; bus_wr = wr;
    bus_ad = ad; bus_tag = tg;
    @(posedge clk); #1;
    reset = 1'b1; bus_astb = 1'b0; bus_atomic = 1'b0; bus_rd = 1'b0; bus_wr = 1'b0;
    bus_ad = '0; bus_tag = '0;
  endtask

  initial begin
    reset = 1'b0; bus_astb = 0; bus_atomic = 0; bus_rd = 0; bus_wr = 0; bus_ad = '0; bus_tag = '0;
    // Reset
    cyc(0, 0, 0, 0, 0, 64'h0, 8'h0);
    cyc(0, 0, 0, 0, 0, 64'h0, 8'h0);
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_rd_tag", {56'h0, rd_tag}, 64'h0);
    chk("rst_err", {63'h0, err}, 64'h0);
    chk("rst_nreads", {32'h0, nreads}, 64'h0);
    chk("rst_nwrites", {32'h0, nwrites}, 64'h0);
    chk("rst_state", 64'(dut.state_q), 64'd0);
    cyc(1, 0, 0, 1, 0, 64'h0, 8'h0);
    chk("idle_rd_err", {63'h0, err}, 64'h1);
    chk("idle_rd_data", rd_data, 64'h0);
    chk("idle_rd_nreads", {32'h0, nreads}, 64'h0);

    // Write then read
    cyc(0, 0, 0, 0, 0, 64'h0, 8'h0);
    cyc(1, 1, 0, 0, 0, 64'h0000_0000_0000_0123, 8'h0);
    cyc(1, 0, 0, 0, 1, 64'hDEADBEEF_01234567, 8'h35);
    cyc(1, 0, 0, 1, 0, 64'h0, 8'h0);
    chk("wr_rd_data", rd_data, 64'hDEADBEEF_01234567);
    chk("wr_rd_tag", {56'h0, rd_tag}, 64'h35);
    chk("wr_rd_nwrites", {32'h0, nwrites}, 64'd1);
    chk("wr_rd_nreads", {32'h0, nreads}, 64'd1);
    chk("wr_rd_err", {63'h0, err}, 64'h0);

    // Atomic read-modify-write with one wait cycle
    cyc(1, 1, 0, 0, 0, 64'h10, 8'h0);
    cyc(1, 0, 1, 1, 0, 64'h0, 8'h0);
    cyc(1, 0, 1, 0, 0, 64'h0, 8'h0);
    chk("atom_wait_state", 64'(dut.state_q), 64'd2);
    cyc(1, 0, 1, 0, 1, 64'h5, 8'h02);
    chk("atom_wr_state", 64'(dut.state_q), 64'd1);
    cyc(1, 0, 0, 1, 0, 64'h0, 8'h0);
    chk("atom_rd_data", rd_data, 64'h5);
    chk("atom_rd_tag", {56'h0, rd_tag}, 64'h02);
    chk("atom_err_clean", {63'h0, err}, 64'h0);
    cyc(1, 0, 1, 1, 0, 64'h0, 8'h0);
    cyc(1, 1, 1, 0, 0, 64'h0123, 8'h0);
    chk("lock_astb_err", {63'h0, err}, 64'h1);
    chk("lock_astb_state", 64'(dut.state_q), 64'd2);
    cyc(1, 0, 1, 0, 1, 64'h77, 8'h03);
    cyc(1, 0, 0, 1, 0, 64'h0, 8'h0);
    chk("lock_wr_addr_kept", rd_data, 64'h77);
    chk("lock_wr_tag", {56'h0, rd_tag}, 64'h03);
    chk("atom_nwrites", {32'h0, nwrites}, 64'd3);
    chk("atom_nreads", {32'h0, nreads}, 64'd5);

    // Range: memory survives reset; out-of-range write discarded, read returns zero
    cyc(0, 0, 0, 0, 0, 64'h0, 8'h0);
    cyc(1, 1, 0, 0, 0, 64'h0123, 8'h0);
    cyc(1, 0, 0, 1, 0, 64'h0, 8'h0);
    chk("keep_after_rst", rd_data, 64'hDEADBEEF_01234567);
    cyc(1, 1, 0, 0, 0, 64'h01123, 8'h0);
    cyc(1, 0, 0, 0, 1, 64'hABC, 8'h11);
    chk("range_wr_nwrites", {32'h0, nwrites}, 64'd0);
    chk("range_wr_err", {63'h0, err}, 64'h1);
    cyc(1, 0, 0, 1, 0, 64'h0, 8'h0);
    chk("range_rd_data", rd_data, 64'h0);
    chk("range_rd_tag", {56'h0, rd_tag}, 64'h0);
    chk("range_rd_nreads", {32'h0, nreads}, 64'd2);
    cyc(1, 1, 0, 0, 0, 64'h0123, 8'h0);
    cyc(1, 0, 0, 1, 0, 64'h0, 8'h0);
    chk("range_no_alias", rd_data, 64'hDEADBEEF_01234567);

    // Illegal rd+wr together in ADDR
    cyc(0, 0, 0, 0, 0, 64'h0, 8'h0);
    cyc(1, 1, 0, 0, 0, 64'h0123, 8'h0);
    cyc(1, 0, 0, 1, 1, 64'h1111, 8'h0);
    chk("rdwr_err", {63'h0, err}, 64'h1);
    chk("rdwr_nreads", {32'h0, nreads}, 64'd0);
    chk("rdwr_nwrites", {32'h0, nwrites}, 64'd0);
    chk("rdwr_rd_data", rd_data, 64'h0);

    // Reset during LOCK aborts the pending write
    cyc(0, 0, 0, 0, 0, 64'h0, 8'h0);
    cyc(1, 1, 0, 0, 0, 64'h0123, 8'h0);
    cyc(1, 0, 1, 1, 0, 64'h0, 8'h0);
    cyc(0, 0, 1, 0, 1, 64'h9999, 8'h99);
    chk("lockrst_state", 64'(dut.state_q), 64'd0);
    cyc(1, 0, 1, 0, 1, 64'h8888, 8'h88);
    chk("lockrst_wr_err", {63'h0, err}, 64'h1);
    chk("lockrst_nwrites", {32'h0, nwrites}, 64'd0);
    cyc(1, 1, 0, 0, 0, 64'h0123, 8'h0);
    cyc(1, 0, 0, 1, 0, 64'h0, 8'h0);
    chk("lockrst_mem_data", rd_data, 64'hDEADBEEF_01234567);
    chk("lockrst_mem_tag", {56'h0, rd_tag}, 64'h35);

`ifdef BUSMEM_PARITY_EN
    cyc(0, 0, 0, 0, 0, 64'h0, 8'h0);
    cyc(1, 1, 0, 0, 0, 64'h0200, 8'h0);
    cyc(1, 0, 0, 0, 1, 64'h0F0F, 8'h0A);
    dut.mem[12'h200][0] = ~dut.mem[12'h200][0];
    cyc(1, 0, 0, 1, 0, 64'h0, 8'h0);
    chk("par_data", rd_data, 64'h0F0E);
    chk("par_tag", {56'h0, rd_tag}, 64'h0A);
    chk("par_err", {63'h0, err}, 64'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
